// File: rtl/stream_packetizer_pkg.sv
// Shared definitions for the stream packetizer: packet layout, FSM encoding
// and default sizing that must agree with the downstream input-port FIFO.
package stream_packetizer_pkg;

  localparam int DEF_PAYLOAD_BITS = 32;
  localparam int DEF_LEAF_BITS    = 5;
  localparam int DEF_PORT_BITS    = 4;
  // Downstream FIFO has ASIZE=5, i.e. 32 entries; keep these in lockstep.
  localparam int DEF_FIFO_DEPTH   = 32;
  localparam int DEF_CREDIT_BITS  = 6;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Packet is {dest_leaf, dest_port, payload}, MSB first.
  localparam int PAYLOAD_LSB = 0;

  function automatic int port_lsb(input int payload_bits);
    return payload_bits;
  endfunction

  function automatic int leaf_lsb(input int payload_bits, input int port_bits);
    return payload_bits + port_bits;
  endfunction

  function automatic int pkt_bits(input int leaf_bits, input int port_bits,
                                  input int payload_bits);
    return leaf_bits + port_bits + payload_bits;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with load and a sticky overflow flag,
// usable on any credit-flow-controlled network port.
module credit_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             err_q, err_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    count_d = count_q;
    err_d   = err_q;
    if (load_i) begin
      count_d = MAX_C;
    end else if (inc_i && !dec_i) begin
      // A return with the counter already full means the far end lost track.
      if (count_q == MAX_C) err_d = 1'b1;
      else                  count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values, so update order inside the block is irrelevant.
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: rtl/stream_packetizer.sv
// Wraps a valid/ready word stream into {leaf, port, payload} network packets,
// gated by downstream credits, with a credit-stall monitoring counter.
module stream_packetizer
  import stream_packetizer_pkg::*;
#(
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int LEAF_BITS    = DEF_LEAF_BITS,
  parameter int PORT_BITS    = DEF_PORT_BITS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int CREDIT_BITS  = DEF_CREDIT_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [PAYLOAD_BITS-1:0]               d_in,
  input  logic                                  vld_in,
  output logic                                  rdy_in,
  input  logic                                  cfg_wr,
  input  logic [LEAF_BITS-1:0]                  cfg_dest_leaf,
  input  logic [PORT_BITS-1:0]                  cfg_dest_port,
  output logic [LEAF_BITS+PORT_BITS+PAYLOAD_BITS-1:0] pkt_out,
  output logic                                  vld_out,
  input  logic                                  rdy_out,
  input  logic                                  credit_ret,
  input  logic                                  is_done_mode_user,
  output logic [CREDIT_BITS-1:0]                credits,
  output logic                                  credit_err,
  output logic [PAYLOAD_BITS-1:0]               stall_cnt
);

  localparam int PKT_W = pkt_bits(LEAF_BITS, PORT_BITS, PAYLOAD_BITS);

  state_e                  state_q, state_d;
  logic [LEAF_BITS-1:0]    leaf_q, leaf_d;
  logic [PORT_BITS-1:0]    port_q, port_d;
  logic [PKT_W-1:0]        pkt_q, pkt_d;
  logic                    vld_q, vld_d;
  logic [PAYLOAD_BITS-1:0] stall_q, stall_d;
  logic                    accept;

  // Credit is reserved at accept time so an in-flight word always has a slot.
  assign rdy_in = (state_q == RUN) && (credits != '0) && (!vld_q || rdy_out);
  assign accept = vld_in && rdy_in;

  always_comb begin
    state_d = state_q;
    leaf_d  = leaf_q;
    port_d  = port_q;
    pkt_d   = pkt_q;
    vld_d   = vld_q;
    stall_d = stall_q;

    if (cfg_wr) begin
      state_d = RUN;
      leaf_d  = cfg_dest_leaf;
      port_d  = cfg_dest_port;
    end

    // A word accepted alongside cfg_wr still carries the old header.
    if (accept) begin
      pkt_d = {leaf_q, port_q, d_in};
      vld_d = 1'b1;
    end else if (rdy_out) begin
      vld_d = 1'b0;
    end

    if (state_q == RUN && vld_in && credits == '0 && !is_done_mode_user)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNCFG;
      leaf_q  <= '0;
      port_q  <= '0;
      pkt_q   <= '0;
      vld_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      leaf_q  <= leaf_d;
      port_q  <= port_d;
      pkt_q   <= pkt_d;
      vld_q   <= vld_d;
      stall_q <= stall_d;
    end
  end

  credit_counter #(
    .WIDTH (CREDIT_BITS),
    .MAX   (FIFO_DEPTH)
  ) u_credit_counter (
    .clk     (clk),
    .reset   (reset),
    .load_i  (cfg_wr),
    .inc_i   (credit_ret && state_q == RUN),
    .dec_i   (accept),
    .count_o (credits),
    .err_o   (credit_err)
  );

  assign pkt_out   = pkt_q;
  assign vld_out   = vld_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_stream_packetizer.sv
// Directed and randomized checks of stream_packetizer against a cycle-level
// behavioural model of packets, credits and the stall counter.
module tb_stream_packetizer;

  localparam int PW    = 32;
  localparam int LW    = 5;
  localparam int TW    = 4;
  localparam int DEPTH = 32;
  localparam int CW    = 6;
  localparam int KW    = LW + TW + PW;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] d_in;
  logic          vld_in;
  logic          rdy_in;
  logic          cfg_wr;
  logic [LW-1:0] cfg_dest_leaf;
  logic [TW-1:0] cfg_dest_port;
  logic [KW-1:0] pkt_out;
  logic          vld_out;
  logic          rdy_out;
  logic          credit_ret;
  logic          is_done_mode_user;
  logic [CW-1:0] credits;
  logic          credit_err;
  logic [PW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit            m_run;
  logic [LW-1:0] m_leaf;
  logic [TW-1:0] m_port;
  int            m_credits;
  bit            m_err;
  logic [PW-1:0] m_stall;
  bit            m_vld;
  logic [KW-1:0] m_pkt;

  always #5 clk = ~clk;

  stream_packetizer dut (
    .clk               (clk),
    .reset             (reset),
    .d_in              (d_in),
    .vld_in            (vld_in),
    .rdy_in            (rdy_in),
    .cfg_wr            (cfg_wr),
    .cfg_dest_leaf     (cfg_dest_leaf),
    .cfg_dest_port     (cfg_dest_port),
    .pkt_out           (pkt_out),
    .vld_out           (vld_out),
    .rdy_out           (rdy_out),
    .credit_ret        (credit_ret),
    .is_done_mode_user (is_done_mode_user),
    .credits           (credits),
    .credit_err        (credit_err),
    .stall_cnt         (stall_cnt)
  );

  function automatic bit model_rdy();
    return m_run && (m_credits != 0) && (!m_vld || rdy_out);
  endfunction

  // Advance one clock and apply the stated rules to the model; inputs are
  // driven on the falling edge, so they are stable across the rising edge.
  task automatic tick();
    bit acc;
    acc = vld_in && model_rdy();
    @(posedge clk);
    if (reset) begin
      m_run = 0; m_leaf = '0; m_port = '0; m_credits = 0;
      m_err = 0; m_stall = '0; m_vld = 0; m_pkt = '0;
    end else begin
      if (m_run && vld_in && m_credits == 0 && !is_done_mode_user)
        m_stall = m_stall + 1;
      if (acc) begin
        m_pkt = {m_leaf, m_port, d_in};
        m_vld = 1;
      end else if (rdy_out) begin
        m_vld = 0;
      end
      if (cfg_wr) m_credits = DEPTH;
      else if (m_run && acc && !credit_ret) m_credits = m_credits - 1;
      else if (m_run && !acc && credit_ret) begin
        if (m_credits == DEPTH) m_err = 1;
        else m_credits = m_credits + 1;
      end
      if (cfg_wr) begin
        m_run = 1; m_leaf = cfg_dest_leaf; m_port = cfg_dest_port;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    vld_in = 0; cfg_wr = 0; credit_ret = 0; is_done_mode_user = 0;
    rdy_out = 1; d_in = '0;
  endtask

  task automatic configure(input logic [LW-1:0] leaf, input logic [TW-1:0] port);
    idle_inputs();
    cfg_wr = 1; cfg_dest_leaf = leaf; cfg_dest_port = port;
    tick();
    cfg_wr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    checks++;
    if (vld_out !== 1'b0 || pkt_out !== '0 || credits !== '0 ||
        credit_err !== 1'b0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: vld=%b pkt=%h cred=%0d err=%b stall=%0d, required all zero",
               vld_out, pkt_out, credits, credit_err, stall_cnt);
    end
    vld_in = 1; d_in = 32'h55;
    for (int i = 0; i < 4; i++) begin
      credit_ret = (i == 2);
      #1;
      checks++;
      if (rdy_in !== 1'b0 || vld_out !== 1'b0 || credits !== '0 || stall_cnt !== '0) begin
        errors++;
        $display("FAIL uncfg_idle: rdy_in=%b vld=%b cred=%0d stall=%0d, required 0 0 0 0",
                 rdy_in, vld_out, credits, stall_cnt);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_basic_stream();
    logic [KW-1:0] exp;
    configure(5'd3, 4'd2);
    for (int i = 0; i < 4; i++) begin
      vld_in = 1; d_in = 32'hA0 + i;
      #1;
      checks++;
      if (rdy_in !== 1'b1) begin
        errors++;
        $display("FAIL basic_rdy_in: got %b, required 1 (word %0d)", rdy_in, i);
      end
      tick();
      exp = {5'd3, 4'd2, 32'(32'hA0 + i)};
      checks++;
      if (vld_out !== 1'b1 || pkt_out !== exp) begin
        errors++;
        $display("FAIL basic_pkt: vld=%b pkt=%h, required vld=1 pkt=%h", vld_out, pkt_out, exp);
      end
    end
    vld_in = 0;
    tick();
    checks++;
    if (credits !== 6'd28 || vld_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_credits: cred=%0d vld=%b, required 28 0", credits, vld_out);
    end
  endtask

  task automatic test_credit_exhaust();
    logic [PW-1:0] base;
    configure(5'd9, 4'd1);
    for (int i = 0; i < DEPTH; i++) begin
      vld_in = 1; d_in = 32'(i);
      #1;
      checks++;
      if (rdy_in !== 1'b1) begin
        errors++;
        $display("FAIL exhaust_rdy: got %b, required 1 at word %0d", rdy_in, i);
      end
      tick();
    end
    base = m_stall;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (rdy_in !== 1'b0) begin
        errors++;
        $display("FAIL exhaust_blocked: rdy_in=%b, required 0", rdy_in);
      end
      tick();
    end
    checks++;
    if (credits !== '0 || stall_cnt !== base + 10) begin
      errors++;
      $display("FAIL exhaust_stall: cred=%0d stall=%0d, required 0 %0d", credits, stall_cnt, base + 10);
    end
    is_done_mode_user = 1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (stall_cnt !== base + 10) begin
      errors++;
      $display("FAIL stall_frozen: got %0d, required %0d", stall_cnt, base + 10);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    logic [KW-1:0] w0, w1, w2;
    configure(5'd17, 4'd7);
    w0 = {5'd17, 4'd7, 32'hCAFE0000};
    w1 = {5'd17, 4'd7, 32'hCAFE0001};
    w2 = {5'd17, 4'd7, 32'hCAFE0002};
    vld_in = 1; d_in = 32'hCAFE0000;
    tick();
    rdy_out = 0; d_in = 32'hCAFE0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rdy_in !== 1'b0 || vld_out !== 1'b1 || pkt_out !== w0) begin
        errors++;
        $display("FAIL bp_hold: rdy_in=%b vld=%b pkt=%h, required 0 1 %h", rdy_in, vld_out, pkt_out, w0);
      end
      tick();
    end
    rdy_out = 1;
    #1;
    checks++;
    if (rdy_in !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_rdy: got %b, required 1", rdy_in);
    end
    tick();
    checks++;
    if (pkt_out !== w1 || vld_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume1: pkt=%h vld=%b, required %h 1", pkt_out, vld_out, w1);
    end
    d_in = 32'hCAFE0002;
    tick();
    checks++;
    if (pkt_out !== w2 || credits !== 6'd29) begin
      errors++;
      $display("FAIL bp_resume2: pkt=%h cred=%0d, required %h 29", pkt_out, credits, w2);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    configure(5'd1, 4'd1);
    vld_in = 1;
    for (int i = 0; i < 25; i++) tick();
    checks++;
    if (credits !== 6'd7) begin
      errors++;
      $display("FAIL simul_setup: cred=%0d, required 7", credits);
    end
    credit_ret = 1;
    tick();
    checks++;
    if (credits !== 6'd7) begin
      errors++;
      $display("FAIL simul_both: cred=%0d, required 7", credits);
    end
    vld_in = 0;
    tick();
    checks++;
    if (credits !== 6'd8) begin
      errors++;
      $display("FAIL simul_ret_only: cred=%0d, required 8", credits);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_overflow();
    configure(5'd2, 4'd3);
    credit_ret = 1;
    tick();
    credit_ret = 0;
    checks++;
    if (credits !== 6'd32 || credit_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: cred=%0d err=%b, required 32 1", credits, credit_err);
    end
    configure(5'd4, 4'd4);
    vld_in = 1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (credit_err !== 1'b1 || credits !== 6'd29) begin
      errors++;
      $display("FAIL ovf_sticky: err=%b cred=%0d, required 1 29", credit_err, credits);
    end
    vld_in = 0; reset = 1;
    tick();
    reset = 0;
    checks++;
    if (credit_err !== 1'b0 || credits !== '0 || vld_out !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reset: err=%b cred=%0d vld=%b, required 0 0 0", credit_err, credits, vld_out);
    end
  endtask

  task automatic test_random();
    configure(5'($urandom), 4'($urandom));
    for (int i = 0; i < 1500; i++) begin
      vld_in            = ($urandom_range(0, 3) != 0);
      d_in              = $urandom;
      rdy_out           = ($urandom_range(0, 3) != 0);
      credit_ret        = ($urandom_range(0, 2) == 0);
      is_done_mode_user = ($urandom_range(0, 7) == 0);
      cfg_wr            = ($urandom_range(0, 99) == 0);
      cfg_dest_leaf     = 5'($urandom);
      cfg_dest_port     = 4'($urandom);
      reset             = ($urandom_range(0, 499) == 0);
      #1;
      checks++;
      if (rdy_in !== model_rdy() || vld_out !== m_vld || credits !== CW'(m_credits) ||
          credit_err !== m_err || stall_cnt !== m_stall || (m_vld && pkt_out !== m_pkt)) begin
        errors++;
        $display("FAIL random_c%0d: rdy=%b vld=%b pkt=%h cred=%0d err=%b stall=%0d, required %b %b %h %0d %b %0d",
                 i, rdy_in, vld_out, pkt_out, credits, credit_err, stall_cnt,
                 model_rdy(), m_vld, m_pkt, m_credits, m_err, m_stall);
      end
      tick();
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    cfg_dest_leaf = '0; cfg_dest_port = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic_stream();
    test_credit_exhaust();
    test_backpressure();
    test_simultaneous();
    test_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
